// File: rtl/divider_pkg.sv
// Shared constants for the sequential restoring divider.
// Latency: n/a (package only).
// Handshake: n/a. Holds the default operand width and the 2-bit FSM state encoding.
package divider_pkg;

  // Default operand / quotient / remainder width.
  localparam int DIV_WIDTH_DEFAULT = 4;

  // FSM state encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/subtractor.sv
// Ripple-borrow subtractor: diff = a - b - borrow_in, with borrow_out.
// Latency: purely combinational.
// Handshake: none.
// Ports: a, b (WIDTH bits) operands; borrow_in; diff (WIDTH bits); borrow_out (1 = a < b + borrow_in).
module subtractor #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  // chain[i] is the borrow into bit i.
  logic [WIDTH:0] chain;

  assign chain[0] = borrow_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    // Full subtractor cell: borrow when a < b, or when a == b and a borrow arrives.
    assign diff[i]    = a[i] ^ b[i] ^ chain[i];
    assign chain[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & chain[i]);
  end

  assign borrow_out = chain[WIDTH];

endmodule

// File: rtl/seq_divider4.sv
// Sequential restoring unsigned divider, one quotient bit per clock.
// Latency: done pulses WIDTH edges after the accepting edge; start-to-start spacing is WIDTH+2 edges.
// Handshake: start is sampled only in IDLE; busy marks RUN, done is a one-cycle pulse in DONE.
// Ports: clk, rst_n (async, active-low); start, dividend, divisor in;
//        busy, done, quotient, remainder, div_by_zero out. The result outputs hold until the next result.
module seq_divider4
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [1:0]       state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [WIDTH-1:0] d_q,         d_d;
  logic [WIDTH-1:0] qw_q,        qw_d;
  logic [WIDTH-1:0] rw_q,        rw_d;
  logic             dbz_q,       dbz_d;
  logic [WIDTH-1:0] quotient_q,  quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_by_zero_q, div_by_zero_d;

  // Shifted partial remainder kept at WIDTH+1 bits so the bit shifted out
  // of Rw still takes part in the compare against D.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  logic           borrow;
  logic           trial_msb_unused;

  assign shifted = {rw_q, qw_q[WIDTH-1]};

  subtractor #(
    .WIDTH (WIDTH + 1)
  ) u_sub (
    .a          (shifted),
    .b          ({1'b0, d_q}),
    .borrow_in  (1'b0),
    .diff       (trial),
    .borrow_out (borrow)
  );

  // A successful trial is always below D, so its top bit is zero.
  assign trial_msb_unused = trial[WIDTH];

  logic [WIDTH-1:0] rw_next;
  logic [WIDTH-1:0] qw_next;

  always_comb begin
    rw_next = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    qw_next = {qw_q[WIDTH-2:0], ~borrow};
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    d_d           = d_q;
    qw_d          = qw_q;
    rw_d          = rw_q;
    dbz_d         = dbz_q;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          d_d     = divisor;
          qw_d    = dividend;
          rw_d    = '0;
          cnt_d   = CNT_W'(WIDTH - 1);
          dbz_d   = (divisor == '0);
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        qw_d  = qw_next;
        rw_d  = rw_next;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          quotient_d    = qw_next;
          remainder_d   = rw_next;
          div_by_zero_d = dbz_q;
          state_d       = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      d_q           <= '0;
      qw_q          <= '0;
      rw_q          <= '0;
      dbz_q         <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      d_q           <= d_d;
      qw_q          <= qw_d;
      rw_q          <= rw_d;
      dbz_q         <= dbz_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
    end
  end

  assign busy        = (state_q == ST_RUN);
  assign done        = (state_q == ST_DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_seq_divider4.sv
// Self-checking bench for seq_divider4 (WIDTH=4) against an arithmetic reference model.
// Latency: n/a. Handshake: drives start/operands at negedges, samples outputs at negedges.
// Ports: none.
module tb_seq_divider4;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int n_tests = 0;
  int n_fail  = 0;

  seq_divider4 #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division; a zero divisor yields all-ones / dividend.
  function automatic void model(input int a, input int b,
                                output int q, output int r, output int dbz);
    if (b == 0) begin
      q = 15; r = a; dbz = 1;
    end else begin
      q = a / b; r = a % b; dbz = 0;
    end
  endfunction

  // Run one division. When noisy, start is held high with 7/7 through RUN and DONE.
  task automatic do_div(input int a, input int b, input bit noisy);
    int q, r, dbz;
    int busy_cnt;
    bit got;
    model(a, b, q, r, dbz);
    @(negedge clk);
    start    = 1'b1;
    dividend = 4'(a);
    divisor  = 4'(b);
    @(posedge clk);
    @(negedge clk);
    busy_cnt = 0;
    got      = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      start = noisy;
      if (noisy) begin
        dividend = 4'd7;
        divisor  = 4'd7;
      end else begin
        dividend = 4'($urandom);
        divisor  = 4'($urandom);
      end
      chk("busy_done_excl", {31'd0, busy & done}, 0);
      if (done) got = 1'b1;
      else begin
        if (busy) busy_cnt++;
        @(negedge clk);
      end
    end
    chk($sformatf("done_seen %0d/%0d", a, b), {31'd0, got}, 1);
    chk($sformatf("busy_cycles %0d/%0d", a, b), busy_cnt, 4);
    chk($sformatf("quot %0d/%0d", a, b), {28'd0, quotient}, q);
    chk($sformatf("rem %0d/%0d", a, b), {28'd0, remainder}, r);
    chk($sformatf("dbz %0d/%0d", a, b), {31'd0, div_by_zero}, dbz);
    if (b != 0) begin
      chk("prop_recon", quotient * b + remainder, a);
      chk("prop_rem_lt", {31'd0, remainder < 4'(b)}, 1);
    end
    if (noisy) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic check_quiet(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      chk(tag, {31'd0, done}, 0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_done"}, {31'd0, done}, 0);
    chk({tag, "_quot"}, {28'd0, quotient}, 0);
    chk({tag, "_rem"},  {28'd0, remainder}, 0);
    chk({tag, "_dbz"},  {31'd0, div_by_zero}, 0);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic case.
    do_div(13, 3, 0);

    // Back-to-back at minimum spacing.
    do_div(15, 1, 0);
    do_div(2, 7, 0);

    // Divide by zero then a normal division clearing the flag.
    do_div(9, 0, 0);
    do_div(8, 2, 0);

    // Results hold while idle.
    repeat (3) @(negedge clk);
    chk("hold_quot", {28'd0, quotient}, 4);
    chk("hold_rem", {28'd0, remainder}, 0);

    // start pulsed during RUN and DONE is ignored: one done, 14/4 result.
    do_div(14, 4, 1);
    check_quiet("no_extra_done", 10);
    chk("noisy_quot", {28'd0, quotient}, 3);
    chk("noisy_rem", {28'd0, remainder}, 2);

    // Reset during the second RUN cycle aborts the operation.
    @(negedge clk);
    start    = 1'b1;
    dividend = 4'd11;
    divisor  = 4'd2;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;
    check_quiet("abort_no_done", 8);
    do_div(11, 2, 0);

    // Exhaustive sweep of all operand pairs.
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        do_div(a, b, 0);

    // Randomized operands, some with start noise.
    for (int k = 0; k < 40; k++)
      do_div(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), bit'($urandom_range(0, 1)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
